// File: rtl/uart_byte_rx.sv
// Purpose: 8N1 UART receiver; oversamples rx_in and presents each byte on a valid/ready register.
// Latency: valid_out rises about 9.5 bit times plus 2-4 clocks after the start-bit falling edge.
// Backpressure: one-entry holding register; a byte completing while it is still full is dropped and overrun_out latches.
module uart_byte_rx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rx_in,
  output logic [7:0] byte_out,
  output logic       valid_out,
  input  logic       ready_in,
  output logic       framing_err_out,
  output logic       overrun_out,
  output logic       busy_out
);

  // The mid-start-bit check needs CLKS_PER_BIT/2-1 to be a distinct, non-negative count, so at least 4.
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             sync_q1;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;

  logic             cnt_mid;
  logic             cnt_last;
  logic             cnt_clr;
  logic             sample_bit;
  logic             stop_good;
  logic             stop_bad;
  logic             xfer;

  assign cnt_mid  = (cnt == CNT_MID);
  assign cnt_last = (cnt == CNT_LAST);
  assign xfer     = valid_out && ready_in;

  // Two-flop synchronizer for the asynchronous line; resets to the idle (high) level.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q1 <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync_q1 <= rx_in;
      rx_s    <= sync_q1;
    end
  end

  // Frame state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: start detect, start-glitch rejection, eight data bits, stop bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt_mid) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (cnt_last && (idx == 3'd7)) state_nxt = STOP;
      end
      STOP: begin
        // Return to IDLE at mid stop bit so a back-to-back start edge is not missed.
        if (cnt_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state control strobes for the counter, shift register and result handling.
  always_comb begin
    cnt_clr    = 1'b0;
    sample_bit = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
      end
      START: begin
        cnt_clr = cnt_mid;
      end
      DATA: begin
        cnt_clr    = cnt_last;
        sample_bit = cnt_last;
      end
      STOP: begin
        cnt_clr   = cnt_last;
        stop_good = cnt_last && rx_s;
        stop_bad  = cnt_last && !rx_s;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Oversampling counter: free-runs within a bit period, cleared at each sampling point.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Data bit index and LSB-first shift register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idx   <= 3'd0;
      shreg <= 8'h00;
    end else if (state != DATA) begin
      idx <= 3'd0;
    end else if (sample_bit) begin
      shreg[idx] <= rx_s;
      idx        <= idx + 3'd1;
    end
  end

  // Framing error pulse and registered busy flag (busy tracks state != IDLE exactly).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      framing_err_out <= 1'b0;
      busy_out        <= 1'b0;
    end else begin
      framing_err_out <= stop_bad;
      busy_out        <= (state_nxt != IDLE);
    end
  end

  // Holding register with valid/ready handshake; a load may coincide with a transfer.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      byte_out    <= 8'h00;
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
    end else if (stop_good) begin
      if (!valid_out || ready_in) begin
        byte_out  <= shreg;
        valid_out <= 1'b1;
      end else begin
        // Register still occupied: keep the old byte stable and record the loss.
        overrun_out <= 1'b1;
      end
    end else if (xfer) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 10 clocks per bit.
// Frames are driven bit by bit; a negedge monitor logs transfers, pulses and stalls.
// Table rows cover single frames; hand sequences cover glitch, back-to-back, overrun and reset.
module tb_uart_byte_rx;

  localparam int CLKS = 10;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rdy;
  logic [7:0] byte_o;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic       busy;

  uart_byte_rx #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD_RATE  (100_000)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rx_in          (rx),
    .byte_out       (byte_o),
    .valid_out      (valid),
    .ready_in       (rdy),
    .framing_err_out(ferr),
    .overrun_out    (ovr),
    .busy_out       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor state, written only by the monitor process.
  logic [7:0] xq[$];
  int         ferr_cnt   = 0;
  int         ferr_long  = 0;
  int         vcyc       = 0;
  int         busy_cnt   = 0;
  int         rise_cyc   = 0;
  int         stall_viol = 0;
  logic       prev_valid = 1'b0;
  logic       prev_rdy   = 1'b0;
  logic       prev_ferr  = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  always @(negedge clk) begin
    if (valid && rdy) xq.push_back(byte_o);
    if (ferr) ferr_cnt++;
    if (ferr && prev_ferr) ferr_long++;
    if (valid && !prev_valid) rise_cyc = cyc;
    if (valid) vcyc++;
    if (busy) busy_cnt++;
    if (rst_n && prev_valid && !prev_rdy && (!valid || byte_o != prev_byte)) stall_viol++;
    prev_valid = valid;
    prev_rdy   = rdy;
    prev_ferr  = ferr;
    prev_byte  = byte_o;
  end

  int total = 0;
  int bad   = 0;
  int start_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_xfer;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n0;
    int f0;
    int v0;
    int b0;
    int lat;

    vecs[0] = '{8'hBB, 1'b1, 1, 0};
    vecs[1] = '{8'h55, 1'b0, 0, 1};
    vecs[2] = '{8'hA3, 1'b1, 1, 0};
    vecs[3] = '{8'h00, 1'b1, 1, 0};
    vecs[4] = '{8'hFF, 1'b1, 1, 0};
    vecs[5] = '{8'h81, 1'b1, 1, 0};

    rst_n = 1'b0;
    rx    = 1'b1;
    rdy   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_byte", int'(byte_o), 0);
    chk("rst_ferr", int'(ferr), 0);
    chk("rst_ovr", int'(ovr), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(10);

    // Single frames with ready high (includes framing error followed by a good frame)
    rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n0 = xq.size();
      f0 = ferr_cnt;
      v0 = vcyc;
      send_frame(vecs[i].data, vecs[i].stop);
      lat = rise_cyc - start_cyc;
      idle(30);
      chk($sformatf("v%0d_xfers", i), xq.size() - n0, vecs[i].exp_xfer);
      chk($sformatf("v%0d_valid_cycles", i), vcyc - v0, vecs[i].exp_xfer);
      chk($sformatf("v%0d_ferr_pulses", i), ferr_cnt - f0, vecs[i].exp_ferr);
      chk($sformatf("v%0d_ferr_single", i), ferr_long, 0);
      chk($sformatf("v%0d_ovr", i), int'(ovr), 0);
      if (vecs[i].exp_xfer == 1 && xq.size() > n0) begin
        chk($sformatf("v%0d_byte", i), int'(xq[xq.size() - 1]), int'(vecs[i].data));
        chk($sformatf("v%0d_latency_97_99", i), int'(lat >= 97 && lat <= 99), 1);
      end
    end

    // Start glitch shorter than half a bit
    b0 = busy_cnt;
    v0 = vcyc;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(20);
    @(negedge clk);
    chk("glitch_busy_seen", int'(busy_cnt > b0), 1);
    chk("glitch_busy_clear", int'(busy), 0);
    chk("glitch_no_valid", vcyc - v0, 0);
    chk("glitch_no_ferr", ferr_cnt - f0, 0);
    chk("glitch_no_ovr", int'(ovr), 0);
    @(posedge clk);
    #1;

    // Back-to-back frames, no idle gap
    n0 = xq.size();
    f0 = ferr_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hBB, 1'b1);
    idle(30);
    chk("b2b_count", xq.size() - n0, 3);
    if (xq.size() >= n0 + 3) begin
      chk("b2b_byte0", int'(xq[n0]), 8'h00);
      chk("b2b_byte1", int'(xq[n0 + 1]), 8'hFF);
      chk("b2b_byte2", int'(xq[n0 + 2]), 8'hBB);
    end
    chk("b2b_no_ferr", ferr_cnt - f0, 0);
    chk("b2b_no_ovr", int'(ovr), 0);

    // Overrun with ready held low
    rdy = 1'b0;
    n0 = xq.size();
    send_frame(8'h12, 1'b1);
    idle(5);
    @(negedge clk);
    chk("ovr_first_valid", int'(valid), 1);
    chk("ovr_first_byte", int'(byte_o), 8'h12);
    chk("ovr_first_flag", int'(ovr), 0);
    @(posedge clk);
    #1;
    send_frame(8'h34, 1'b1);
    idle(10);
    @(negedge clk);
    chk("ovr_flag_set", int'(ovr), 1);
    chk("ovr_held_valid", int'(valid), 1);
    chk("ovr_held_byte", int'(byte_o), 8'h12);
    chk("ovr_no_xfer", xq.size() - n0, 0);
    chk("ovr_stall_stable", stall_viol, 0);
    @(posedge clk);
    #1;
    rdy = 1'b1;
    @(negedge clk);
    chk("ovr_xfer_valid", int'(valid), 1);
    chk("ovr_xfer_byte", int'(byte_o), 8'h12);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ovr_valid_drop", int'(valid), 0);
    chk("ovr_sticky", int'(ovr), 1);
    chk("ovr_one_xfer", xq.size() - n0, 1);
    if (xq.size() > n0) chk("ovr_xfer_value", int'(xq[n0]), 8'h12);
    @(posedge clk);
    #1;

    // Reset mid-DATA of 0x7E, then a clean 0xC3
    n0 = xq.size();
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_byte", int'(byte_o), 0);
    chk("mid_rst_ferr", int'(ferr), 0);
    chk("mid_rst_ovr", int'(ovr), 0);
    chk("mid_rst_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(20);
    chk("aborted_no_xfer", xq.size() - n0, 0);
    send_frame(8'hC3, 1'b1);
    idle(30);
    chk("post_rst_count", xq.size() - n0, 1);
    if (xq.size() > n0) chk("post_rst_byte", int'(xq[xq.size() - 1]), 8'hC3);
    chk("post_rst_ovr", int'(ovr), 0);
    chk("final_stall_stable", stall_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Serial-to-byte receiver between the FTDI USB module's TX line and the UART RX bridge that assembles headers and messages.
- Oversamples the asynchronous 8N1 line and recovers bytes LSB first.
- Holds each received byte in a one-entry output register, presented on a valid/ready handshake that matches the bridge's ll_valid/ll_byte/ll_ready interface.
- Reports framing errors and overruns.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- BAUD_RATE, 115_200, line bit rate.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD_RATE (derived localparam; must be >= 4), clock cycles per bit.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- rx_in  input  1  raw UART line from FTDI, asynchronous, idle high.
- byte_out  output  8  received byte; stable while valid_out is high.
- valid_out  output  1  byte_out holds an unconsumed byte; connects to bridge ll_valid_in.
- ready_in  input  1  downstream accepts the byte; connects to bridge ll_ready_out.
- framing_err_out  output  1  single-cycle pulse when a stop bit samples low.
- overrun_out  output  1  sticky flag: a completed byte was dropped because the holding register was full.
- busy_out  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset: one clock, clk_in; reset is asynchronous and active-low (rst_n_in).
  - While rst_n_in is low, byte_out=0, valid_out=0, framing_err_out=0, overrun_out=0, busy_out=0, state=IDLE, counters=0.
  - Both synchronizer flops reset to 1.
  - Reset mid-frame abandons the frame; no partial byte is ever presented.
- Synchronizer: rx_in passes through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
- Bit counter cnt: counts 0..CLKS_PER_BIT-1. Bit index: 0..7.
- IDLE: rx_s==0 -> START, cnt=0.
- START: at cnt==CLKS_PER_BIT/2-1 (mid start bit):
  - rx_s==0 -> DATA, cnt=0, idx=0.
  - rx_s==1 -> IDLE (glitch rejected, no flags).
- DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into the shift register at bit idx (LSB first) and reset cnt.
  - After idx 7 -> STOP, cnt=0.
- STOP: at cnt==CLKS_PER_BIT-1 (mid stop bit):
  - rx_s==1 -> byte complete -> load attempt.
  - rx_s==0 -> framing_err_out pulses high for exactly the next cycle; byte discarded.
  - Either case -> IDLE immediately, so a start bit arriving half a bit later is caught (back-to-back frames).
- Load attempt:
  - If valid_out==0, or valid_out&&ready_in in the same cycle: byte_out<=shift reg, valid_out<=1 next cycle.
  - Otherwise (valid_out=1, ready_in=0): new byte dropped, byte_out unchanged, overrun_out<=1. overrun_out clears only on reset.
- Handshake:
  - Transfer occurs on any cycle with valid_out&&ready_in.
  - valid_out drops the following cycle unless a load coincides; in that case valid_out stays 1 and byte_out takes the new byte.
  - valid_out never depends combinationally on ready_in.
  - byte_out never changes while valid_out=1 and ready_in=0.
- Latency: valid_out rises between 9.5*CLKS_PER_BIT+2 and 9.5*CLKS_PER_BIT+4 cycles after the rx_in falling edge of the start bit.
- busy_out = (state != IDLE), registered.

Test Plan:
All scenarios use CLK_FREQ_HZ=1_000_000 and BAUD_RATE=100_000, so CLKS_PER_BIT=10.
1. ready_in=1; drive frame 0xBB (bits 1,1,0,1,1,1,0,1 LSB first, stop=1) -> byte_out=0xBB with valid_out high for exactly 1 cycle, within 97-99 cycles of the start edge; framing_err_out=0, overrun_out=0.
2. rx_in low for 3 cycles then high -> busy_out asserts then returns to 0; valid_out, framing_err_out, overrun_out stay 0.
3. Frame 0x55 with stop bit driven 0 -> framing_err_out single-cycle pulse; valid_out stays 0; the next valid frame 0xA3 is received correctly.
4. ready_in=0; send 0x12 then 0x34 -> valid_out=1 with byte_out=0x12 held throughout; overrun_out=1 after the second stop bit. Then raise ready_in -> 0x12 transfers, valid_out=0 next cycle, overrun_out stays 1.
5. ready_in=1; back-to-back frames 0x00, 0xFF, 0xBB with no idle gap -> three transfers in order, values 0x00, 0xFF, 0xBB, no errors.
6. Assert rst_n_in low mid-DATA of 0x7E, release, then send 0xC3 -> all outputs 0 during reset; no byte from the aborted frame; exactly one transfer of 0xC3 follows.
